jk_bank_ctrl: RTL and testbench

JK_BANK_CTRL -- requirements
Module: jk_bank_ctrl

---
 rtl/jk_bank_ctrl.sv | 144 ++++++++++++++
 tb/tb_jk_bank_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_ctrl.sv
// ============================================================================
// Module   : jk_bank_ctrl
// Purpose  : Drives the J/K inputs of an external JK flip-flop bank to LOAD,
//            TOGGLE or step-count it up/down, with abort and done reporting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_bank_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [1:0] c_OP_LOAD   = 2'b00;
  localparam logic [1:0] c_OP_TOGGLE = 2'b01;
  localparam logic [1:0] c_OP_UP     = 2'b10;
  localparam logic [1:0] c_OP_DOWN   = 2'b11;

  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_cnt;
  logic             r_aborted;
  logic             r_live;
  logic             w_accept;
  logic [WIDTH-1:0] w_up;
  logic [WIDTH-1:0] w_dn;

  // r_live holds cmd_ready low until the first edge after reset release
  assign cmd_ready = r_live && (r_state == c_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign busy      = (r_state == c_EXEC) || (r_state == c_DONE);
  assign done      = (r_state == c_DONE);
  assign aborted   = done && r_aborted;
  assign result    = done ? q : '0;

  // Toggle enables of a synchronous binary counter built from the bank
  assign w_up[0] = 1'b1;
  assign w_dn[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
      assign w_up[gi] = &q[gi-1:0];
      assign w_dn[gi] = &(~q[gi-1:0]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= c_IDLE;
      r_op      <= 2'b00;
      r_data    <= '0;
      r_cnt     <= '0;
      r_aborted <= 1'b0;
      r_live    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_op      <= cmd_op;
            r_data    <= cmd_data;
            r_cnt     <= cmd_data;
            r_aborted <= 1'b0;
            // A zero-length count has nothing to execute
            if (cmd_op[1] && (cmd_data == '0)) r_state <= c_DONE;
            else                               r_state <= c_EXEC;
          end
        end
        c_EXEC: begin
          if (!r_op[1]) begin
            r_state <= c_DONE;
          end else if (abort) begin
            r_aborted <= 1'b1;
            r_state   <= c_DONE;
          end else begin
            r_cnt <= r_cnt - c_ONE;
            if (r_cnt == c_ONE) r_state <= c_DONE;
          end
        end
        c_DONE: begin
          r_aborted <= 1'b0;
          r_state   <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    if (r_state == c_EXEC) begin
      case (r_op)
        c_OP_LOAD: begin
          j = r_data;
          k = ~r_data;
        end
        c_OP_TOGGLE: begin
          j = r_data;
          k = r_data;
        end
        c_OP_UP: begin
          if (!abort) begin
            j = w_up;
            k = w_up;
          end
        end
        c_OP_DOWN: begin
          if (!abort) begin
            j = w_dn;
            k = w_dn;
          end
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jk_bank_ctrl.sv
// ============================================================================
// Module   : tb_jk_bank_ctrl
// Purpose  : Directed self-checking bench for jk_bank_ctrl with a JK bank model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_bank_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       abort;
  logic [3:0] q;
  logic [3:0] j;
  logic [3:0] k;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [3:0] result;

  logic       bank_set;
  logic [3:0] bank_val;

  int n_assert = 0;
  int n_fail   = 0;
  int ab_stray = 0;
  int lat;
  int done_seen;
  logic [3:0] res;
  logic       ab;
  logic [3:0] hq [0:63];
  logic [3:0] hj [0:63];
  logic [3:0] hk [0:63];

  jk_bank_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .abort     (abort),
    .q         (q),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .result    (result)
  );

  always #5 clk = ~clk;

  // External JK bank, not reset by the controller
  always @(posedge clk) begin
    if (bank_set) q <= bank_val;
    else          q <= (j & ~q) | (~k & q);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_bank(input logic [3:0] v);
    @(negedge clk);
    bank_set = 1'b1;
    bank_val = v;
    @(negedge clk);
    bank_set = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    chk("accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Cycle c = c-th negedge after the accept edge; latency = first c with done
  task automatic wait_done(output int l, output logic [3:0] r, output logic a);
    l = 0;
    r = 4'hx;
    a = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      hq[c] = q;
      hj[c] = j;
      hk[c] = k;
      if (done) begin
        l = c;
        r = result;
        a = aborted;
        break;
      end
      if (aborted !== 1'b0) ab_stray++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'h0;
    abort     = 1'b0;
    bank_set  = 1'b1;
    bank_val  = 4'h0;
    #1 reset = 1'b0;
    #1;
    chk("rst_ready",   32'(cmd_ready), 32'd0);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_done",    32'(done),      32'd0);
    chk("rst_aborted", 32'(aborted),   32'd0);
    chk("rst_j",       32'(j),         32'd0);
    chk("rst_k",       32'(k),         32'd0);
    chk("rst_result",  32'(result),    32'd0);
    repeat (2) @(negedge clk);
    bank_set = 1'b0;
    reset = 1'b1;
    #1 chk("ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_edge", 32'(cmd_ready), 32'd1);

    // LOAD A from bank 0
    issue(2'b00, 4'hA);
    wait_done(lat, res, ab);
    chk("load_lat", 32'(lat), 32'd2);
    chk("load_res", 32'(res), 32'hA);
    chk("load_ab",  32'(ab),  32'd0);
    chk("load_j",   32'(hj[1]), 32'hA);
    chk("load_k",   32'(hk[1]), 32'h5);
    chk("load_busy_exec", 32'(busy), 32'd1);

    // TOGGLE mask 3 on A
    issue(2'b01, 4'h3);
    wait_done(lat, res, ab);
    chk("tog_lat", 32'(lat), 32'd2);
    chk("tog_res", 32'(res), 32'h9);
    chk("tog_ab",  32'(ab),  32'd0);
    chk("tog_jk",  32'({hj[1], hk[1]}), 32'h33);

    // COUNT_UP 3 from E wraps through 0
    set_bank(4'hE);
    issue(2'b10, 4'd3);
    wait_done(lat, res, ab);
    chk("up_lat",  32'(lat), 32'd4);
    chk("up_res",  32'(res), 32'h1);
    chk("up_q2",   32'(hq[2]), 32'hF);
    chk("up_q3",   32'(hq[3]), 32'h0);
    chk("up_j1",   32'(hj[1]), 32'h1);
    chk("up_j2",   32'(hj[2]), 32'hF);

    // COUNT_DOWN 2 from 1 wraps to F
    issue(2'b11, 4'd2);
    wait_done(lat, res, ab);
    chk("dn_lat", 32'(lat), 32'd3);
    chk("dn_res", 32'(res), 32'hF);
    chk("dn_q2",  32'(hq[2]), 32'h0);
    chk("dn_j2",  32'(hj[2]), 32'hF);
    chk("dn_ab",  32'(ab), 32'd0);
    @(negedge clk);
    chk("idle_jk_after_done", 32'({j, k}), 32'h00);

    // COUNT_UP 10 from 0, abort in 4th EXEC cycle
    set_bank(4'h0);
    issue(2'b10, 4'd10);
    repeat (4) @(negedge clk);
    chk("abort_q_before", 32'(q), 32'h3);
    abort = 1'b1;
    #1;
    chk("abort_jk", 32'({j, k}), 32'h00);
    chk("abort_done_low", 32'(done), 32'd0);
    wait_done(lat, res, ab);
    abort = 1'b0;
    chk("abort_lat", 32'(lat), 32'd1);
    chk("abort_res", 32'(res), 32'h3);
    chk("abort_flag", 32'(ab), 32'd1);

    // COUNT_UP 0: straight to DONE
    issue(2'b10, 4'd0);
    wait_done(lat, res, ab);
    chk("zero_lat", 32'(lat), 32'd1);
    chk("zero_res", 32'(res), 32'h3);
    chk("zero_ab",  32'(ab),  32'd0);
    chk("zero_jk",  32'({j, k}), 32'h00);

    // cmd_valid held through busy: second command waits for IDLE
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 4'h5;
    chk("hold_ready0", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_op   = 2'b01;
    cmd_data = 4'h1;
    chk("hold_ready_exec", 32'(cmd_ready), 32'd0);
    chk("hold_busy_exec",  32'(busy),      32'd1);
    @(negedge clk);
    chk("hold_done1",  32'(done),      32'd1);
    chk("hold_res1",   32'(result),    32'h5);
    chk("hold_ready_done", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("hold_ready_idle", 32'(cmd_ready), 32'd1);
    chk("hold_busy_idle",  32'(busy),      32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hold_busy2", 32'(busy), 32'd1);
    @(negedge clk);
    chk("hold_done2", 32'(done),   32'd1);
    chk("hold_res2",  32'(result), 32'h4);

    // Reset in the middle of COUNT_UP 8 from 4
    set_bank(4'h4);
    issue(2'b10, 4'd8);
    repeat (4) @(negedge clk);
    chk("mid_q", 32'(q), 32'h7);
    reset = 1'b0;
    #1;
    chk("mid_rst_jk",    32'({j, k}),     32'h00);
    chk("mid_rst_busy",  32'(busy),       32'd0);
    chk("mid_rst_ready", 32'(cmd_ready),  32'd0);
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
      chk("mid_frozen", 32'(q), 32'h7);
    end
    reset = 1'b1;
    #1 chk("mid_ready_release", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    if (done !== 1'b0) done_seen++;
    chk("mid_no_done", 32'(done_seen), 32'd0);
    chk("mid_ready_edge", 32'(cmd_ready), 32'd1);

    issue(2'b11, 4'd1);
    wait_done(lat, res, ab);
    chk("post_lat", 32'(lat), 32'd2);
    chk("post_res", 32'(res), 32'h6);
    chk("aborted_only_with_done", 32'(ab_stray), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
